fetch_sequencer: RTL and testbench

- Drives pipeline stage 1.
- Owns the program counter and issues instruction-memory requests, at most one outstanding.
- Buffers a returned instruction while the hazard unit stalls.
- Applies branch/jump redirects, and produces the instr/PC/flush/hazard signals consumed by the fetch stage register.

---
 rtl/fetch_sequencer_pkg.sv | 16 +
 rtl/fetch_hold_buf.sv | 29 ++
 rtl/fetch_sequencer.sv | 134 +++++++++++++
 tb/tb_fetch_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, bubble encoding
// and default PC parameters.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        FS_ISSUE = 2'd0,
        FS_WAIT  = 2'd1,
        FS_HOLD  = 2'd2,
        FS_DRAIN = 2'd3
    } fs_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int unsigned DEFAULT_PC_STEP  = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry instruction buffer that keeps a returned instruction while the
// hazard unit holds the pipeline.
module fetch_hold_buf #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid
);

    // NOTE: the data register is reset as well as the valid bit; it is a
    // single flop row, and a known value keeps bubbles clean downstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Pipeline stage-1 fetch sequencer: owns the PC, issues one instruction-memory
// request at a time, buffers under stall and applies branch/jump redirects.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int unsigned       PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               stall_in,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               fetch_valid_out,
    output logic [INSTR_W-1:0] fetch_instrn_out,
    output logic [ADDR_W-1:0]  fetch_pc_out,
    output logic               fetch_flush_out,
    output logic               fetch_hazard_out
);

    localparam logic [INSTR_W-1:0] BUBBLE = INSTR_W'(NOP_INSTR);
    localparam logic [ADDR_W-1:0]  STEP   = ADDR_W'(PC_STEP);

    fs_state_t          state, state_nxt;
    logic [ADDR_W-1:0]  pc_reg, pc_nxt;
    logic [ADDR_W-1:0]  inflight_pc, inflight_nxt;
    logic               deliver;
    logic [INSTR_W-1:0] deliver_instr;
    logic               hold_load, hold_clear, hold_valid;
    logic [INSTR_W-1:0] hold_data;

    fetch_hold_buf #(.W(INSTR_W)) u_hold_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (hold_load),
        .clear (hold_clear),
        .din   (imem_rsp_data),
        .dout  (hold_data),
        .valid (hold_valid)
    );

    assign imem_req_addr = pc_reg;

    // NOTE: every signal written here gets a default first so no latch is
    // inferred on paths that leave it untouched.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc_reg;
        inflight_nxt   = inflight_pc;
        hold_load      = 1'b0;
        hold_clear     = 1'b0;
        deliver        = 1'b0;
        deliver_instr  = BUBBLE;
        imem_req_valid = (state == FS_ISSUE) && rst_n && !stall_in && !redirect_valid;

        if (redirect_valid) begin
            pc_nxt     = redirect_pc;
            hold_clear = 1'b1;
            // An outstanding response still has to be swallowed unless it is
            // arriving right now.
            if (state == FS_WAIT || state == FS_DRAIN)
                state_nxt = imem_rsp_valid ? FS_ISSUE : FS_DRAIN;
            else
                state_nxt = FS_ISSUE;
        end else begin
            case (state)
                FS_ISSUE: begin
                    if (imem_req_valid && imem_req_ready) begin
                        inflight_nxt = pc_reg;
                        pc_nxt       = pc_reg + STEP;
                        state_nxt    = FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (stall_in) begin
                            hold_load = 1'b1;
                            state_nxt = FS_HOLD;
                        end else begin
                            deliver       = 1'b1;
                            deliver_instr = imem_rsp_data;
                            state_nxt     = FS_ISSUE;
                        end
                    end
                end
                FS_HOLD: begin
                    if (!stall_in) begin
                        deliver       = hold_valid;
                        deliver_instr = hold_data;
                        hold_clear    = 1'b1;
                        state_nxt     = FS_ISSUE;
                    end
                end
                FS_DRAIN: begin
                    if (imem_rsp_valid)
                        state_nxt = FS_ISSUE;
                end
                default: state_nxt = FS_ISSUE;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= FS_ISSUE;
            pc_reg           <= RESET_PC;
            inflight_pc      <= '0;
            fetch_valid_out  <= 1'b0;
            fetch_instrn_out <= BUBBLE;
            fetch_pc_out     <= '0;
            fetch_flush_out  <= 1'b0;
            fetch_hazard_out <= 1'b0;
        end else begin
            state            <= state_nxt;
            pc_reg           <= pc_nxt;
            inflight_pc      <= inflight_nxt;
            fetch_valid_out  <= deliver;
            fetch_instrn_out <= deliver ? deliver_instr : BUBBLE;
            fetch_pc_out     <= deliver ? inflight_pc + STEP : '0;
            fetch_flush_out  <= redirect_valid;
            fetch_hazard_out <= stall_in && !deliver;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a transaction-level reference model
// (outstanding / discard / held-instruction bookkeeping) checked every cycle.
module tb_fetch_sequencer;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        stall_in = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_valid_out;
    logic [31:0] fetch_instrn_out;
    logic [31:0] fetch_pc_out;
    logic        fetch_flush_out;
    logic        fetch_hazard_out;

    fetch_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .stall_in         (stall_in),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .fetch_valid_out  (fetch_valid_out),
        .fetch_instrn_out (fetch_instrn_out),
        .fetch_pc_out     (fetch_pc_out),
        .fetch_flush_out  (fetch_flush_out),
        .fetch_hazard_out (fetch_hazard_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Logs and memory handshake observed by the checker.
    logic [31:0] req_log[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_instr[$];
    logic        acc = 1'b0;
    logic [31:0] acc_addr = 32'h0;

    // Reference model state.
    bit          mdl_live = 0;
    logic [31:0] m_pc = 32'h0, m_out_pc = 32'h0, m_held_i = 32'h0;
    bit          m_out = 0, m_drop = 0, m_held_v = 0;
    logic        e_valid, e_flush, e_hazard;
    logic [31:0] e_instr, e_pc;

    always @(negedge clk) begin
        logic        e_req, dv;
        logic [31:0] di, dp;
        if (mdl_live) begin
            check("valid_out", fetch_valid_out, e_valid);
            check("instrn_out", fetch_instrn_out, e_instr);
            check("pc_out", fetch_pc_out, e_pc);
            check("flush_out", fetch_flush_out, e_flush);
            check("hazard_out", fetch_hazard_out, e_hazard);
        end
        e_req = rst_n && !m_out && !m_held_v && !stall_in && !redirect_valid;
        if (mdl_live) begin
            check("req_valid", imem_req_valid, e_req);
            if (e_req) check("req_addr", imem_req_addr, m_pc);
        end
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        if (acc) req_log.push_back(imem_req_addr);
        if (mdl_live && fetch_valid_out === 1'b1) begin
            dlv_pc.push_back(fetch_pc_out);
            dlv_instr.push_back(fetch_instrn_out);
        end

        dv = 0; di = 32'h0; dp = 32'h0;
        if (!rst_n) begin
            m_pc = 32'h0; m_out = 0; m_drop = 0; m_held_v = 0;
        end else if (redirect_valid) begin
            if (imem_rsp_valid && m_out) begin
                m_out = 0; m_drop = 0;
            end else if (m_out) begin
                m_drop = 1;
            end
            m_held_v = 0;
            m_pc = redirect_pc;
        end else if (imem_rsp_valid && m_out) begin
            m_out = 0;
            if (m_drop) m_drop = 0;
            else if (stall_in) begin m_held_v = 1; m_held_i = imem_rsp_data; end
            else begin dv = 1; di = imem_rsp_data; dp = m_out_pc + 32'd4; end
        end else if (m_held_v) begin
            if (!stall_in) begin dv = 1; di = m_held_i; dp = m_out_pc + 32'd4; m_held_v = 0; end
        end else if (e_req && imem_req_ready) begin
            m_out = 1; m_out_pc = m_pc; m_pc = m_pc + 32'd4;
        end
        e_valid  = rst_n && dv;
        e_instr  = rst_n ? di : 32'h0;
        e_pc     = rst_n ? dp : 32'h0;
        e_flush  = rst_n && redirect_valid;
        e_hazard = rst_n && stall_in && !dv;
        mdl_live = 1;
    end

    // Memory: fixed latency per request, one response per accepted request.
    int          cyc = 0;
    int          mem_lat = 1;
    int          due_q[$];
    logic [31:0] addr_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            due_q.push_back(cyc - 1 + mem_lat);
            addr_q.push_back(acc_addr);
        end
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = addr_q[0] ^ KEY;
            void'(due_q.pop_front());
            void'(addr_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic wait_accept();
        int n = req_log.size();
        int k = 0;
        while (req_log.size() == n && k < 30) begin tick(); k++; end
        check("accept_seen", 32'(req_log.size() > n), 32'd1);
    endtask

    task automatic wait_deliver();
        int k = 0;
        while (fetch_valid_out !== 1'b1 && k < 30) begin tick(); k++; end
        check("deliver_seen", 32'(fetch_valid_out), 32'd1);
    endtask

    initial begin
        int snap;
        tick(); tick();
        check("rst_valid", fetch_valid_out, 0);
        check("rst_instrn", fetch_instrn_out, 0);
        check("rst_pc", fetch_pc_out, 0);
        check("rst_flush", fetch_flush_out, 0);
        check("rst_hazard", fetch_hazard_out, 0);
        rst_n = 1'b1;
        #1;
        check("first_req_valid", imem_req_valid, 1);
        check("first_req_addr", imem_req_addr, 32'h0);

        // Free run with single-cycle memory until addr 8 has been requested.
        begin
            int k = 0;
            while (req_log.size() < 3 && k < 30) begin tick(); k++; end
        end
        check("req0", req_log[0], 32'h0);
        check("req1", req_log[1], 32'h4);
        check("req2", req_log[2], 32'h8);
        check("dlv_count", dlv_pc.size(), 2);
        check("dlv0_pc", dlv_pc[0], 32'h4);
        check("dlv0_instr", dlv_instr[0], 32'hA5A5_0000);
        check("dlv1_pc", dlv_pc[1], 32'h8);
        check("dlv1_instr", dlv_instr[1], 32'hA5A5_0004);

        // Stall for 5 cycles starting as the response for addr 8 arrives.
        check("rsp8_arrives", imem_rsp_valid, 1);
        stall_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hazard_stall", fetch_hazard_out, 1);
            check("no_deliver_stall", fetch_valid_out, 0);
        end
        check("no_req_stall", req_log.size(), 3);
        stall_in = 1'b0;
        tick();
        #1;
        check("held_valid", fetch_valid_out, 1);
        check("held_pc", fetch_pc_out, 32'hC);
        check("held_instr", fetch_instrn_out, 32'hA5A5_0008);
        check("held_hazard", fetch_hazard_out, 0);
        check("req12_valid", imem_req_valid, 1);
        check("req12_addr", imem_req_addr, 32'hC);
        tick();
        check("held_once", fetch_valid_out, 0);

        // Redirect while waiting on a slow response.
        mem_lat = 3;
        wait_accept();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("rd_flush", fetch_flush_out, 1);
        check("rd_valid", fetch_valid_out, 0);
        check("rd_drain_noreq", imem_req_valid, 0);
        tick();
        check("rd_flush_pulse", fetch_flush_out, 0);
        check("rd_late_rsp", imem_rsp_valid, 1);
        tick();
        #1;
        check("rd_stale_dropped", fetch_valid_out, 0);
        check("rd_req_valid", imem_req_valid, 1);
        check("rd_req_addr", imem_req_addr, 32'h100);
        wait_deliver();
        check("rd_dlv_pc", fetch_pc_out, 32'h104);
        check("rd_dlv_instr", fetch_instrn_out, 32'hA5A5_0100);

        // Redirect coinciding with the response.
        mem_lat = 1;
        wait_accept();
        check("rs_rsp_now", imem_rsp_valid, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("rs_flush", fetch_flush_out, 1);
        check("rs_valid", fetch_valid_out, 0);
        check("rs_req_valid", imem_req_valid, 1);
        check("rs_req_addr", imem_req_addr, 32'h200);
        tick();
        check("rs_flush_pulse", fetch_flush_out, 0);
        check("rs_rsp_dropped", fetch_valid_out, 0);

        // Reset while waiting; the stale response lands during ISSUE.
        mem_lat = 3;
        wait_deliver();
        wait_accept();
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        stall_in = 1'b1;
        #1;
        check("mr_valid", fetch_valid_out, 0);
        check("mr_instrn", fetch_instrn_out, 0);
        check("mr_pc", fetch_pc_out, 0);
        check("mr_flush", fetch_flush_out, 0);
        check("mr_hazard", fetch_hazard_out, 0);
        snap = dlv_pc.size();
        tick();
        check("mr_stale_rsp", imem_rsp_valid, 1);
        tick();
        stall_in = 1'b0;
        #1;
        check("mr_req_valid", imem_req_valid, 1);
        check("mr_req_addr", imem_req_addr, 32'h0);
        check("mr_no_dlv", dlv_pc.size(), snap);
        wait_deliver();
        check("mr_dlv_pc", fetch_pc_out, 32'h4);
        check("mr_dlv_instr", fetch_instrn_out, 32'hA5A5_0000);

        // Back-pressure, then sequential wrap past the top of the address space.
        mem_lat = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        tick();
        tick();
        imem_req_ready = 1'b1;
        #1;
        check("wr_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        wait_deliver();
        #1;
        check("wr_dlv_pc", fetch_pc_out, 32'h0);
        check("wr_dlv_instr", fetch_instrn_out, 32'h5A5A_FFFC);
        check("wr_req_valid", imem_req_valid, 1);
        check("wr_req_addr_wrap", imem_req_addr, 32'h0);
        check("wr_logged", req_log[req_log.size() - 1], 32'hFFFF_FFFC);

        for (int i = 0; i < 6; i++) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
